// File: rtl/alu_flags_writeback_pkg.sv
// Shared types for the ALU flags/writeback stage.
// ALU_PARITY_FLAG_EN adds a parity bit to the flags struct.
package alu_flags_writeback_pkg;

    typedef logic [63:0] long_t;

    typedef enum logic [1:0] {
        BITS_8  = 2'd0,
        BITS_16 = 2'd1,
        BITS_32 = 2'd2,
        BITS_64 = 2'd3
    } size_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic sign;
`ifdef ALU_PARITY_FLAG_EN
        logic parity;
`endif
    } flags_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/alu_result_mask.sv
// Combinational operand-size masking and zero/sign(/parity) flag derivation.
// Parity is produced only when ALU_PARITY_FLAG_EN is defined.
module alu_result_mask
    import alu_flags_writeback_pkg::*;
(
    input  long_t  raw,
    input  logic   carry,
    input  size_e  size,
    output long_t  masked,
    output flags_t flags
);

    always_comb begin
        masked      = raw;
        flags       = '0;
        flags.carry = carry;
        case (size)
            BITS_8: begin
                masked     = {56'd0, raw[7:0]};
                flags.sign = raw[7];
            end
            BITS_16: begin
                masked     = {48'd0, raw[15:0]};
                flags.sign = raw[15];
            end
            BITS_32: begin
                masked     = {32'd0, raw[31:0]};
                flags.sign = raw[31];
            end
            BITS_64: begin
                masked     = raw;
                flags.sign = raw[63];
            end
            default: begin
                masked     = raw;
                flags.sign = raw[63];
            end
        endcase
        flags.zero = (masked == '0);
`ifdef ALU_PARITY_FLAG_EN
        flags.parity = ^masked;
`endif
    end

endmodule

// File: rtl/alu_flags_writeback.sv
// Registered ALU result/flags stage with 2-entry skid buffer and carry flag.
// ALU_PARITY_FLAG_EN adds the out_parity port and per-entry parity storage.
//
// state | meaning
// EMPTY | no entries, out_valid=0, in_ready=1
// ONE   | head valid, skid free, in_ready=1
// FULL  | head and skid valid, in_ready=0
module alu_flags_writeback
    import alu_flags_writeback_pkg::*;
#(
    parameter int DEST_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_result,
    input  logic              in_carry,
    input  logic [1:0]        in_size,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              in_upd_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_result,
    output logic [DEST_W-1:0] out_dest,
    output logic              out_zero,
    output logic              out_sign,
`ifdef ALU_PARITY_FLAG_EN
    output logic              out_parity,
`endif
    output logic              carry_flag
);

    generate
        if (DEPTH != 2) begin : g_bad_depth
            $error("alu_flags_writeback: DEPTH must be 2");
        end
    endgenerate

    typedef struct packed {
        long_t             result;
        logic [DEST_W-1:0] dest;
        logic              zero;
        logic              sign;
`ifdef ALU_PARITY_FLAG_EN
        logic              parity;
`endif
    } entry_t;

    long_t      new_result;
    flags_t     new_flags;
    entry_t     new_entry;
    entry_t     head;
    entry_t     skid;
    buf_state_e state;
    logic       accept;
    logic       drain;

    alu_result_mask u_mask (
        .raw    (in_result),
        .carry  (in_carry),
        .size   (size_e'(in_size)),
        .masked (new_result),
        .flags  (new_flags)
    );

    always_comb begin
        new_entry        = '0;
        new_entry.result = new_result;
        new_entry.dest   = in_dest;
        new_entry.zero   = new_flags.zero;
        new_entry.sign   = new_flags.sign;
`ifdef ALU_PARITY_FLAG_EN
        new_entry.parity = new_flags.parity;
`endif
    end

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // in_ready is only dropped while both entries are occupied, so accept never lands in FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            head       <= '0;
            skid       <= '0;
            carry_flag <= 1'b0;
        end else begin
            if (accept && in_upd_flags) begin
                carry_flag <= new_flags.carry;
            end
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head      <= new_entry;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !drain) begin
                        skid     <= new_entry;
                        in_ready <= 1'b0;
                        state    <= FULL;
                    end else if (!accept && drain) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end else if (accept && drain) begin
                        head <= new_entry;
                    end
                end
                FULL: begin
                    if (drain) begin
                        head     <= skid;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_result = head.result;
    assign out_dest   = head.dest;
    assign out_zero   = head.zero;
    assign out_sign   = head.sign;
`ifdef ALU_PARITY_FLAG_EN
    assign out_parity = head.parity;
`endif

endmodule

// File: tb/tb_alu_flags_writeback.sv
// Randomized + directed bench for alu_flags_writeback against a queue-based reference model.
// Parity checks are compiled in when ALU_PARITY_FLAG_EN is defined.
module tb_alu_flags_writeback;

    localparam int DEST_W = 5;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [63:0]       in_result;
    logic              in_carry;
    logic [1:0]        in_size;
    logic [DEST_W-1:0] in_dest;
    logic              in_upd_flags;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_result;
    logic [DEST_W-1:0] out_dest;
    logic              out_zero;
    logic              out_sign;
`ifdef ALU_PARITY_FLAG_EN
    logic              out_parity;
`endif
    logic              carry_flag;

    alu_flags_writeback #(.DEST_W(DEST_W), .DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_carry     (in_carry),
        .in_size      (in_size),
        .in_dest      (in_dest),
        .in_upd_flags (in_upd_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_dest     (out_dest),
        .out_zero     (out_zero),
        .out_sign     (out_sign),
`ifdef ALU_PARITY_FLAG_EN
        .out_parity   (out_parity),
`endif
        .carry_flag   (carry_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]       result;
        logic [DEST_W-1:0] dest;
        logic              zero;
        logic              sign;
        logic              parity;
    } exp_t;

    exp_t q[$];
    logic m_carry;
    int   n_cmp;
    int   n_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: keep the low (8 << size) bits, flags read off the kept value.
    function automatic exp_t ref_entry(input logic [63:0] r, input logic [1:0] s,
                                       input logic [DEST_W-1:0] d);
        exp_t        e;
        int          bits;
        logic [63:0] m;
        bits = 8 << s;
        m    = (bits == 64) ? r : (r & ((64'd1 << bits) - 64'd1));
        e.result = m;
        e.dest   = d;
        e.zero   = (m == 64'd0);
        e.sign   = m[bits-1];
        e.parity = ($countones(m) % 2) == 1;
        return e;
    endfunction

    task automatic check_model();
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        chk("carry_flag", carry_flag, m_carry);
        if (q.size() > 0) begin
            chk("out_result", out_result, q[0].result);
            chk("out_dest", out_dest, q[0].dest);
            chk("out_zero", out_zero, q[0].zero);
            chk("out_sign", out_sign, q[0].sign);
`ifdef ALU_PARITY_FLAG_EN
            chk("out_parity", out_parity, q[0].parity);
`endif
        end
    endtask

    // One cycle: check at the negedge, drive, advance past posedge, update model.
    task automatic cycle(input logic v, input logic [63:0] r, input logic c,
                         input logic [1:0] s, input logic [DEST_W-1:0] d,
                         input logic u, input logic ordy);
        logic acc;
        logic drn;
        check_model();
        in_valid     = v;
        in_result    = r;
        in_carry     = c;
        in_size      = s;
        in_dest      = d;
        in_upd_flags = u;
        out_ready    = ordy;
        acc = v && (q.size() < 2);
        drn = (q.size() > 0) && ordy;
        @(posedge clk);
        if (drn) void'(q.pop_front());
        if (acc) begin
            q.push_back(ref_entry(r, s, d));
            if (u) m_carry = c;
        end
        @(negedge clk);
    endtask

    task automatic idle_cycle(input logic ordy);
        cycle(1'b0, {$urandom, $urandom}, 1'b0, 2'($urandom_range(3)), '0, 1'b0, ordy);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        m_carry = 1'b0;
        rst_n        = 1'b0;
        in_valid     = 1'b1;
        in_result    = 64'h1234_5678_9ABC_DEF0;
        in_carry     = 1'b1;
        in_size      = 2'd3;
        in_dest      = 5'd9;
        in_upd_flags = 1'b1;
        out_ready    = 1'b0;

        // Reset held with in_valid asserted.
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_carry", carry_flag, 1'b0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_dest", out_dest, 0);
        chk("rst_zero_sign", {out_zero, out_sign}, 2'b00);
        rst_n = 1'b1;

        // First accept right after release, visible one cycle later.
        cycle(1'b1, 64'h0000_0000_0000_00AB, 1'b0, 2'd0, 5'd7, 1'b0, 1'b1);
        chk("first_valid", out_valid, 1'b1);
        chk("first_result", out_result, 64'hAB);

        // Masking to operand size.
        cycle(1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2'd0, 5'd2, 1'b0, 1'b1);
        chk("b8_result", out_result, 64'h80);
        chk("b8_sign_zero", {out_sign, out_zero}, 2'b10);
        cycle(1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2'd1, 5'd3, 1'b0, 1'b1);
        chk("b16_result", out_result, 64'hFF80);
        chk("b16_sign", out_sign, 1'b1);
        cycle(1'b1, 64'h0000_0001_0000_0000, 1'b0, 2'd2, 5'd4, 1'b0, 1'b1);
        chk("b32_result", out_result, 64'd0);
        chk("b32_zero", out_zero, 1'b1);
        cycle(1'b1, 64'h0000_0001_0000_0000, 1'b0, 2'd3, 5'd5, 1'b0, 1'b1);
        chk("b64_zero_sign", {out_zero, out_sign}, 2'b00);
        chk("b64_result", out_result, 64'h1_0000_0000);

        // Carry update on accept; holds when upd=0.
        cycle(1'b1, 64'h1, 1'b1, 2'd3, 5'd6, 1'b1, 1'b1);
        chk("carry_set", carry_flag, 1'b1);
        cycle(1'b1, 64'h2, 1'b0, 2'd3, 5'd7, 1'b0, 1'b1);
        chk("carry_hold", carry_flag, 1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // Backpressure: three back-to-back ops, only two fit.
        cycle(1'b1, 64'h11, 1'b0, 2'd0, 5'd1, 1'b0, 1'b0);
        cycle(1'b1, 64'h22, 1'b0, 2'd0, 5'd2, 1'b0, 1'b0);
        chk("bp_in_ready_low", in_ready, 1'b0);
        repeat (3) cycle(1'b1, 64'h33, 1'b0, 2'd0, 5'd3, 1'b0, 1'b0);
        chk("bp_head_dest", out_dest, 5'd1);
        cycle(1'b1, 64'h33, 1'b0, 2'd0, 5'd3, 1'b0, 1'b1);
        chk("bp_skid_to_head", out_dest, 5'd2);
        cycle(1'b1, 64'h33, 1'b0, 2'd0, 5'd3, 1'b0, 1'b1);
        cycle(1'b0, 64'h0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1);
        idle_cycle(1'b1);

        // Streaming: one result per cycle.
        for (int i = 0; i < 20; i++)
            cycle(1'b1, {$urandom, $urandom}, 1'($urandom), 2'($urandom_range(3)),
                  DEST_W'(i), 1'($urandom), 1'b1);

        // Async reset mid-stream.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_carry", carry_flag, 1'b0);
        q.delete();
        m_carry = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(9) < 7), {$urandom, $urandom}, 1'($urandom),
                  2'($urandom_range(3)), DEST_W'($urandom), 1'($urandom),
                  ($urandom_range(9) < 6));
        for (int i = 0; i < 4; i++) idle_cycle(1'b1);
        check_model();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
